// File: rtl/dtw_job_sched.sv
// Round-robin job scheduler that shares one dtw_core among NUM_CH sources.
// Grants a channel, latches its job configuration, pulses core start and muxes
// the granted FIFO onto the core source port. Core results are tagged with the
// channel index on their way to the result FIFO. A watchdog aborts stalled jobs.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no job; waiting for enable and a requesting channel
//   S_START | core_start held high until the core reports running
//   S_FEED  | granted FIFO muxed onto the core source port until cnt==target
//   S_RUN   | all samples delivered; waiting for the core to finish
//   S_DONE  | one-cycle completion pulse; rr pointer moves past the grant
module dtw_job_sched #(
    parameter int NUM_CH   = 2,
    parameter int DWIDTH   = 32,
    parameter int SQG_SIZE = 250,
    parameter int REF_LEN  = 29898,
    parameter int TIMEOUT  = 65535,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     op_mode_cfg,
    input  logic [31:0]              ref_len_cfg,
    input  logic                     err_clr,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_empty,
    input  logic [NUM_CH*DWIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_rden,
    output logic                     core_start,
    output logic                     core_op_mode,
    output logic [31:0]              core_ref_len,
    output logic                     core_abort,
    input  logic                     core_running,
    input  logic                     core_src_rden,
    output logic                     core_src_empty,
    output logic [DWIDTH-1:0]        core_src_data,
    input  logic                     core_sink_wren,
    output logic                     core_sink_full,
    input  logic [31:0]              core_sink_data,
    output logic                     res_wren,
    input  logic                     res_full,
    output logic [31:0]              res_data,
    output logic [CH_W-1:0]          res_ch,
    output logic [NUM_CH-1:0]        grant,
    output logic                     busy,
    output logic                     done_pulse,
    output logic                     err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FEED  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Watchdog is a down-counter; it fires when it sits at zero with no activity.
    localparam logic [31:0]     WD_LOAD  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic [31:0]     SQG_LEN  = 32'(SQG_SIZE);
    localparam logic [31:0]     RST_RLEN = 32'(REF_LEN);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]     gidx_q, gidx_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic                op_mode_q, op_mode_d;
    logic [31:0]         ref_len_q, ref_len_d;
    logic [31:0]         target_q, target_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [31:0]         wd_q, wd_d;
    logic                start_q, start_d;
    logic                abort_q, abort_d;
    logic                err_q, err_d;

    logic                pick_found;
    logic [CH_W-1:0]     pick_idx;
    logic [CH_W:0]       cand;
    logic [CH_W-1:0]     g_next;
    logic                feeding;
    logic                src_accept;
    logic                sink_act;
    logic                res_wr;
    logic                wd_active;
    logic                wd_fire;

    // Round-robin pick: first requester at or after the rr pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (CH_W + 1)'(k);
            if (cand >= (CH_W + 1)'(NUM_CH)) begin
                cand = cand - (CH_W + 1)'(NUM_CH);
            end
            if (ch_req[cand[CH_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CH_W-1:0];
            end
        end
    end

    // Pointer value that skips past the channel currently granted.
    always_comb begin
        g_next = (gidx_q == LAST_CH) ? '0 : gidx_q + 1'b1;
    end

    // Source and sink datapath muxing for the granted channel.
    always_comb begin
        feeding        = (state_q == S_FEED) && (cnt_q != target_q);
        src_accept     = feeding && core_src_rden && !ch_empty[gidx_q];
        ch_rden        = src_accept ? grant_q : '0;
        core_src_empty = feeding ? ch_empty[gidx_q] : 1'b1;
        core_src_data  = (state_q == S_FEED) ? ch_data[gidx_q*DWIDTH +: DWIDTH] : '0;

        sink_act       = (state_q != S_IDLE);
        res_wr         = sink_act && core_sink_wren && !res_full;
        core_sink_full = sink_act ? res_full : 1'b1;
        res_wren       = res_wr;
        res_data       = sink_act ? core_sink_data : '0;
        res_ch         = sink_act ? gidx_q : '0;
    end

    // Next-state logic: job sequencing, sample counting, watchdog and error flag.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        op_mode_d = op_mode_q;
        ref_len_d = ref_len_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        abort_d   = 1'b0;
        err_d     = err_q;
        wd_d      = wd_q;
        wd_fire   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && pick_found) begin
                    state_d   = S_START;
                    grant_d   = NUM_CH'(1) << pick_idx;
                    gidx_d    = pick_idx;
                    op_mode_d = op_mode_cfg;
                    ref_len_d = ref_len_cfg;
                    target_d  = op_mode_cfg ? ref_len_cfg : SQG_LEN;
                    cnt_d     = '0;
                    start_d   = 1'b1;
                end
            end
            S_START: begin
                if (core_running) begin
                    state_d = S_FEED;
                    start_d = 1'b0;
                end
            end
            S_FEED: begin
                // The cnt==target cycle is also the one where the source looks empty.
                if (cnt_q == target_q) begin
                    state_d = S_RUN;
                end else if (src_accept) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                if (!core_running) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                rr_d    = g_next;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                start_d = 1'b0;
            end
        endcase

        if (err_clr) begin
            err_d = 1'b0;
        end

        // Any progress (state move, source read, result write) reloads the timer.
        wd_active = (state_q == S_START) || (state_q == S_FEED) || (state_q == S_RUN);
        if (!wd_active || (state_d != state_q) || src_accept || res_wr) begin
            wd_d = WD_LOAD;
        end else if (wd_q != 32'd0) begin
            wd_d = wd_q - 32'd1;
        end else if (TIMEOUT != 0) begin
            wd_fire = 1'b1;
        end

        // A stalled job is abandoned; the pointer moves on so others get served.
        if (wd_fire) begin
            state_d = S_IDLE;
            grant_d = '0;
            rr_d    = g_next;
            start_d = 1'b0;
            abort_d = 1'b1;
            err_d   = 1'b1;
            wd_d    = WD_LOAD;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            op_mode_q <= 1'b0;
            ref_len_q <= RST_RLEN;
            target_q  <= '0;
            cnt_q     <= '0;
            wd_q      <= WD_LOAD;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            op_mode_q <= op_mode_d;
            ref_len_q <= ref_len_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
        end
    end

    // Registered control outputs.
    always_comb begin
        core_start   = start_q;
        core_abort   = abort_q;
        core_op_mode = op_mode_q;
        core_ref_len = ref_len_q;
        grant        = grant_q;
        busy         = (state_q != S_IDLE);
        done_pulse   = (state_q == S_DONE);
        err_timeout  = err_q;
    end

endmodule

// File: tb/tb_dtw_job_sched.sv
// Directed bench for dtw_job_sched with a small FIFO/core model driven from one
// initial block. Inputs change and outputs are sampled on the falling edge.
module tb_dtw_job_sched;

    localparam int          NUM_CH  = 2;
    localparam int          DW      = 32;
    localparam int          CH_W    = 1;
    localparam logic [31:0] RST_RLEN = 32'd29898;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 op_mode_cfg = 1'b0;
    logic [31:0]          ref_len_cfg = 32'd0;
    logic                 err_clr = 1'b0;
    logic [NUM_CH-1:0]    ch_req = '0;
    logic [NUM_CH-1:0]    ch_empty = '1;
    logic [NUM_CH*DW-1:0] ch_data = '0;
    logic [NUM_CH-1:0]    ch_rden;
    logic                 core_start;
    logic                 core_op_mode;
    logic [31:0]          core_ref_len;
    logic                 core_abort;
    logic                 core_running = 1'b0;
    logic                 core_src_rden = 1'b1;
    logic                 core_src_empty;
    logic [DW-1:0]        core_src_data;
    logic                 core_sink_wren = 1'b0;
    logic                 core_sink_full;
    logic [31:0]          core_sink_data = 32'd0;
    logic                 res_wren;
    logic                 res_full = 1'b0;
    logic [31:0]          res_data;
    logic [CH_W-1:0]      res_ch;
    logic [NUM_CH-1:0]    grant;
    logic                 busy;
    logic                 done_pulse;
    logic                 err_timeout;

    dtw_job_sched #(
        .NUM_CH  (NUM_CH),
        .DWIDTH  (DW),
        .SQG_SIZE(250),
        .REF_LEN (29898),
        .TIMEOUT (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .op_mode_cfg   (op_mode_cfg),
        .ref_len_cfg   (ref_len_cfg),
        .err_clr       (err_clr),
        .ch_req        (ch_req),
        .ch_empty      (ch_empty),
        .ch_data       (ch_data),
        .ch_rden       (ch_rden),
        .core_start    (core_start),
        .core_op_mode  (core_op_mode),
        .core_ref_len  (core_ref_len),
        .core_abort    (core_abort),
        .core_running  (core_running),
        .core_src_rden (core_src_rden),
        .core_src_empty(core_src_empty),
        .core_src_data (core_src_data),
        .core_sink_wren(core_sink_wren),
        .core_sink_full(core_sink_full),
        .core_sink_data(core_sink_data),
        .res_wren      (res_wren),
        .res_full      (res_full),
        .res_data      (res_data),
        .res_ch        (res_ch),
        .grant         (grant),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    logic [31:0] ptr [NUM_CH];
    logic [31:0] avail [NUM_CH];
    bit          pat_empty = 1'b0;
    bit          pat_full = 1'b0;
    bit          sink_en = 1'b1;
    int          abort_cnt = 0;

    int          job_ch = 0;
    logic        job_op = 1'b0;
    logic [31:0] job_rl = 32'd0;
    logic [31:0] job_tgt = 32'd0;
    logic [31:0] job_fed = 32'd0;
    bit          job_gseen = 1'b0;
    int          job_done = 0;
    bit          job_abort = 1'b0;
    int          tail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sample_val(input int ch, input logic [31:0] idx);
        return (32'(ch) << 16) + idx + 32'd1;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_abort"}, core_abort, 0);
        chk({tag, "_done"}, done_pulse, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_ch_rden"}, ch_rden, 0);
        chk({tag, "_src_empty"}, core_src_empty, 1);
        chk({tag, "_sink_full"}, core_sink_full, 1);
        chk({tag, "_ref_len"}, core_ref_len, RST_RLEN);
        chk({tag, "_op_mode"}, core_op_mode, 0);
        chk({tag, "_res_wren"}, res_wren, 0);
    endtask

    task automatic begin_job(input int ch, input logic op, input logic [31:0] rl);
        job_ch    = ch;
        job_op    = op;
        job_rl    = rl;
        job_tgt   = op ? rl : 32'd250;
        job_fed   = 32'd0;
        job_gseen = 1'b0;
        job_done  = 0;
        job_abort = 1'b0;
        tail      = 0;
    endtask

    // One clock: drive FIFO/core inputs, check outputs, then update the model.
    task automatic tick();
        logic [NUM_CH-1:0] exp_mask;
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*DW +: DW] = sample_val(i, ptr[i]);
            ch_empty[i] = (ptr[i] >= avail[i]) || (pat_empty && (cyc_n % 6 == 0));
        end
        res_full       = pat_full && (cyc_n % 7 == 0);
        core_sink_wren = core_running && sink_en && (cyc_n % 2 == 0);
        core_sink_data = 32'hC000_0000 + 32'(cyc_n);
        #1;
        exp_mask = NUM_CH'(1) << job_ch;
        chk("rden_wrong_ch", ch_rden & ~exp_mask, 0);
        chk("rden_under_empty", ch_rden & ch_empty, 0);
        chk("res_wren_gate", res_wren, core_sink_wren & ~res_full);
        if (ch_rden != '0) begin
            chk("src_data", core_src_data, sample_val(job_ch, ptr[job_ch]));
            chk("src_empty_on_read", core_src_empty, 0);
        end
        if ((grant & ch_empty) != '0) begin
            chk("src_empty_follow", core_src_empty, 1);
        end
        if (res_wren) begin
            chk("res_data", res_data, core_sink_data);
            chk("res_ch", res_ch, job_ch);
        end
        if (grant != '0 && !job_gseen) begin
            job_gseen = 1'b1;
            chk("grant_order", grant, exp_mask);
            chk("op_mode_latched", core_op_mode, job_op);
            chk("ref_len_latched", core_ref_len, job_rl);
            chk("core_start_at_grant", core_start, 1);
        end
        if (done_pulse) job_done++;
        if (core_abort) begin
            abort_cnt++;
            job_abort = 1'b1;
            chk("abort_grant_idle", grant, 0);
            core_running = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rden[i]) begin
                ptr[i]  = ptr[i] + 32'd1;
                job_fed = job_fed + 32'd1;
            end
        end
        if (core_start && !core_running) begin
            core_running = 1'b1;
        end else if (core_running && job_fed == job_tgt) begin
            tail++;
            if (tail >= 3) core_running = 1'b0;
        end
    endtask

    // stop_at < 0 runs to completion or abort; otherwise stops at that sample count.
    task automatic run_until(input int stop_at, input int budget, input string tag);
        int n = 0;
        while (job_done == 0 && !job_abort && !(stop_at >= 0 && job_fed >= 32'(stop_at))
               && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_budget_expired"}, (n >= budget), 0);
    endtask

    task automatic check_job(input string tag, input bit exp_abort, input logic [31:0] exp_fed);
        chk({tag, "_granted"}, job_gseen, 1);
        chk({tag, "_samples"}, job_fed, exp_fed);
        chk({tag, "_done_cnt"}, job_done, exp_abort ? 0 : 1);
        chk({tag, "_aborted"}, job_abort, exp_abort);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            ptr[i]   = 32'd0;
            avail[i] = 32'd1000000;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        rst_n  = 1'b1;
        enable = 1'b1;

        // T1: ch0 query job, 250 samples 1..250, extra reads blocked
        ch_req = 2'b01; op_mode_cfg = 1'b0; ref_len_cfg = 32'd777;
        begin_job(0, 1'b0, 32'd777);
        run_until(-1, 600, "t1");
        check_job("t1", 1'b0, 32'd250);
        ch_req = 2'b00;

        // T4: ch1 reference-load job of 1000 samples
        ch_req = 2'b10; op_mode_cfg = 1'b1; ref_len_cfg = 32'd1000;
        begin_job(1, 1'b1, 32'd1000);
        run_until(-1, 1500, "t4");
        check_job("t4", 1'b0, 32'd1000);
        ch_req = 2'b00;

        // T2: both channels requesting, alternating grants
        ch_req = 2'b11; op_mode_cfg = 1'b0; ref_len_cfg = 32'd500;
        for (int j = 0; j < 6; j++) begin
            begin_job(j % 2, 1'b0, 32'd500);
            run_until(-1, 600, "t2");
            check_job("t2", 1'b0, 32'd250);
        end
        ch_req = 2'b00;

        // T3: periodic empty and full back-pressure
        pat_empty = 1'b1; pat_full = 1'b1; ch_req = 2'b01;
        begin_job(0, 1'b0, 32'd500);
        run_until(-1, 900, "t3");
        check_job("t3", 1'b0, 32'd250);
        ch_req = 2'b00; pat_empty = 1'b0; pat_full = 1'b0;

        // T5: ch0 starves after 10 samples, watchdog aborts, ch1 served next
        sink_en = 1'b0;
        avail[0] = ptr[0] + 32'd10;
        ch_req = 2'b01;
        begin_job(0, 1'b0, 32'd500);
        run_until(-1, 400, "t5");
        check_job("t5", 1'b1, 32'd10);
        chk("t5_err_set", err_timeout, 1);
        ch_req = 2'b11;
        begin_job(1, 1'b0, 32'd500);
        run_until(-1, 600, "t5b");
        check_job("t5b", 1'b0, 32'd250);
        ch_req = 2'b00;
        chk("t5_err_sticky", err_timeout, 1);
        chk("t5_abort_cycles", abort_cnt, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_err_cleared", err_timeout, 0);
        avail[0] = 32'd1000000;

        // T6: reset in the middle of feeding, then restart from ch0
        ch_req = 2'b01;
        begin_job(0, 1'b0, 32'd500);
        run_until(50, 600, "t6");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("t6_reset");
        core_running = 1'b0;
        core_sink_wren = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ch_req = 2'b11;
        begin_job(0, 1'b0, 32'd500);
        run_until(-1, 600, "t6b");
        check_job("t6b", 1'b0, 32'd250);
        ch_req = 2'b00;
        sink_en = 1'b1;

        // T7: enable and request drop mid-job; job finishes, no new grant
        ch_req = 2'b10;
        begin_job(1, 1'b0, 32'd500);
        run_until(20, 600, "t7");
        enable = 1'b0;
        ch_req = 2'b00;
        run_until(-1, 600, "t7b");
        check_job("t7", 1'b0, 32'd250);
        ch_req = 2'b11;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("t7_no_grant", grant, 0);
        end
        ch_req = 2'b00;
        enable = 1'b1;

        // T8: zero-length reference job goes straight through
        ch_req = 2'b01; op_mode_cfg = 1'b1; ref_len_cfg = 32'd0;
        begin_job(0, 1'b1, 32'd0);
        run_until(-1, 100, "t8");
        check_job("t8", 1'b0, 32'd0);
        ch_req = 2'b00;
        tick();
        chk("t8_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
